// File: rtl/mem_responder_if.sv
// Cache-line request/response bundle between a cache controller (master) and mem_responder (slave).
// The rsp_err signal exists only when RESP_ERR_EN is defined.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] req_addr;
    logic              req_read;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wvalid;
    logic              req_ack;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              busy;
    logic [2:0]        state;
`ifdef RESP_ERR_EN
    logic              rsp_err;
`endif

    modport master (
        output req_addr, req_read, req_write, req_wdata, req_wvalid,
`ifdef RESP_ERR_EN
        input  rsp_err,
`endif
        input  req_ack, rsp_valid, rsp_rdata, rsp_last, busy, state
    );

    modport slave (
        input  req_addr, req_read, req_write, req_wdata, req_wvalid,
`ifdef RESP_ERR_EN
        output rsp_err,
`endif
        output req_ack, rsp_valid, rsp_rdata, rsp_last, busy, state
    );
endinterface

// File: rtl/mem_responder.sv
// Line-burst memory model answering cache fills and writebacks after a fixed latency.
// Optional feature macro RESP_ERR_EN: out-of-range addresses end in a one-cycle error response.
module mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_W   = IDX_W - BEAT_W;
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(LINE_WORDS - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RBURST = 3'd2,
        S_WBURST = 3'd3,
`ifdef RESP_ERR_EN
        S_ERR    = 3'd5,
`endif
        S_RESP   = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_is_read;
    logic              r_ack;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic [HI_W-1:0]   r_line_hi;
    logic [BEAT_W-1:0] r_beat;
    logic [LAT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_req;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [BEAT_W-1:0] w_rd_beat;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_unused_addr;

`ifdef RESP_ERR_EN
    logic r_oor;
    logic r_rsp_err;
    logic w_oor;
    assign w_oor         = |bus.req_addr[ADDR_W-1:2+IDX_W];
    assign w_unused_addr = ^bus.req_addr[2+BEAT_W-1:0];
`else
    // Upper address bits alias onto the same memory in this build.
    assign w_unused_addr = ^{bus.req_addr[ADDR_W-1:2+IDX_W], bus.req_addr[2+BEAT_W-1:0]};
`endif

    assign w_req = bus.req_read | bus.req_write;

    // The RAM read is registered, so fetch one beat ahead of the beat being presented.
    assign w_rd_beat = (r_state == S_RBURST) ? r_beat + BEAT_W'(1) : r_beat;
    assign w_rd_idx  = {r_line_hi, w_rd_beat};
    assign w_wr_idx  = {r_line_hi, r_beat};
    assign w_mem_we  = (r_state == S_WBURST) && bus.req_wvalid;
`ifdef RESP_ERR_EN
    assign w_mem_re  = (((r_state == S_WAIT) && r_is_read) || (r_state == S_RBURST)) && !r_oor;
`else
    assign w_mem_re  = ((r_state == S_WAIT) && r_is_read) || (r_state == S_RBURST);
`endif

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= bus.req_wdata;
        end
        if (w_mem_re) begin
            r_mem_rdata <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_is_read   <= 1'b0;
            r_ack       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_line_hi   <= '0;
            r_beat      <= '0;
            r_wait_cnt  <= '0;
`ifdef RESP_ERR_EN
            r_oor       <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // A simultaneous read and write resolves to the read.
                        r_state    <= S_WAIT;
                        r_ack      <= 1'b1;
                        r_is_read  <= bus.req_read;
                        r_line_hi  <= bus.req_addr[2+BEAT_W +: HI_W];
                        r_beat     <= '0;
                        r_wait_cnt <= LAT_W'(LATENCY);
`ifdef RESP_ERR_EN
                        r_oor      <= w_oor;
`endif
                    end
                end
                S_WAIT: begin
                    // The ack cycle precedes LATENCY further wait cycles.
                    if (r_wait_cnt == '0) begin
`ifdef RESP_ERR_EN
                        if (r_oor) begin
                            r_state     <= S_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_last  <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else
`endif
                        if (r_is_read) begin
                            r_state     <= S_RBURST;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_WBURST;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - LAT_W'(1);
                    end
                end
                S_RBURST: begin
                    r_beat <= r_beat + BEAT_W'(1);
                    if (r_beat == PENULT_BEAT) begin
                        r_rsp_last <= 1'b1;
                    end
                    if (r_beat == LAST_BEAT) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                    end
                end
                S_WBURST: begin
                    if (bus.req_wvalid) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_last  <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_last  <= 1'b0;
                end
`ifdef RESP_ERR_EN
                S_ERR: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_last  <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack   = r_ack;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.rsp_rdata = (r_state == S_RBURST) ? r_mem_rdata : '0;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.state     = r_state;
`ifdef RESP_ERR_EN
    assign bus.rsp_err   = r_rsp_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: line writes, reads, stalls, busy/simultaneous requests and reset abort.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_w [4];

    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_responder #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .DEPTH(256), .LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s_state", tag), bus.state, 3'd0);
        chk($sformatf("%s_busy", tag), bus.busy, 1'b0);
        chk($sformatf("%s_ack", tag), bus.req_ack, 1'b0);
        chk($sformatf("%s_valid", tag), bus.rsp_valid, 1'b0);
        chk($sformatf("%s_last", tag), bus.rsp_last, 1'b0);
        chk($sformatf("%s_rdata", tag), bus.rsp_rdata, 32'h0);
    endtask

    task automatic read_line(input string tag, input logic [31:0] addr, input bit also_write, input bit poke_busy);
        bus.req_addr  = addr;
        bus.req_read  = 1'b1;
        bus.req_write = also_write;
        tick();
        chk($sformatf("%s_ack", tag), bus.req_ack, 1'b1);
        chk($sformatf("%s_wait_state", tag), bus.state, 3'd1);
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        repeat (4) begin
            tick();
            chk($sformatf("%s_wait_valid", tag), bus.rsp_valid, 1'b0);
            chk($sformatf("%s_wait_rdata", tag), bus.rsp_rdata, 32'h0);
            chk($sformatf("%s_wait_ack", tag), bus.req_ack, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_beat%0d_valid", tag, i), bus.rsp_valid, 1'b1);
            chk($sformatf("%s_beat%0d_rdata", tag, i), bus.rsp_rdata, exp_w[i]);
            chk($sformatf("%s_beat%0d_last", tag, i), bus.rsp_last, (i == 3));
            chk($sformatf("%s_beat%0d_ack", tag, i), bus.req_ack, 1'b0);
            chk($sformatf("%s_beat%0d_state", tag, i), bus.state, 3'd2);
            if (poke_busy) bus.req_read = (i < 2);
        end
        bus.req_read = 1'b0;
        tick();
        chk_idle($sformatf("%s_end", tag));
        $display("read %s addr=0x%08h done", tag, addr);
    endtask

    task automatic write_line(input string tag, input logic [31:0] addr, input int stall_after,
                              input int stall_len, input int abort_after);
        bus.req_addr  = addr;
        bus.req_write = 1'b1;
        tick();
        chk($sformatf("%s_ack", tag), bus.req_ack, 1'b1);
        chk($sformatf("%s_wait_state", tag), bus.state, 3'd1);
        bus.req_write = 1'b0;
        repeat (4) tick();
        chk($sformatf("%s_wait_end", tag), bus.state, 3'd1);
        tick();
        chk($sformatf("%s_wburst", tag), bus.state, 3'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == abort_after) begin
                #2;
                rst = 1'b0;
                #1;
                chk_idle($sformatf("%s_abort", tag));
                bus.req_wvalid = 1'b0;
                tick();
                chk_idle($sformatf("%s_abort_hold", tag));
                rst = 1'b1;
                $display("write %s addr=0x%08h aborted after %0d beats", tag, addr, i);
                return;
            end
            if (i == stall_after) begin
                bus.req_wvalid = 1'b0;
                repeat (stall_len) begin
                    tick();
                    chk($sformatf("%s_stall_state", tag), bus.state, 3'd3);
                    chk($sformatf("%s_stall_valid", tag), bus.rsp_valid, 1'b0);
                end
            end
            bus.req_wvalid = 1'b1;
            bus.req_wdata  = exp_w[i];
            tick();
            if (i < 3) chk($sformatf("%s_beat%0d_state", tag, i), bus.state, 3'd3);
        end
        bus.req_wvalid = 1'b0;
        chk($sformatf("%s_resp_state", tag), bus.state, 3'd4);
        chk($sformatf("%s_resp_valid", tag), bus.rsp_valid, 1'b1);
        chk($sformatf("%s_resp_last", tag), bus.rsp_last, 1'b1);
        chk($sformatf("%s_resp_rdata", tag), bus.rsp_rdata, 32'h0);
        tick();
        chk_idle($sformatf("%s_end", tag));
        $display("write %s addr=0x%08h done", tag, addr);
    endtask

    initial begin
        bus.req_addr   = '0;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_wdata  = '0;
        bus.req_wvalid = 1'b0;

        #2;
        chk_idle("reset");
        repeat (2) tick();
        rst = 1'b1;

        // Accept a request, then drop reset in the middle of the ack cycle.
        bus.req_addr = 32'h20;
        bus.req_read = 1'b1;
        tick();
        chk("pre_rst_ack", bus.req_ack, 1'b1);
        chk("pre_rst_busy", bus.busy, 1'b1);
        bus.req_read = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_idle("async_rst");
        tick();
        rst = 1'b1;
        $display("async reset during WAIT done");

        exp_w[0] = 32'hA0; exp_w[1] = 32'hA1; exp_w[2] = 32'hA2; exp_w[3] = 32'hA3;
        write_line("wr20", 32'h20, -1, 0, -1);
        read_line("rd20", 32'h20, 1'b0, 1'b0);
        read_line("rd2c", 32'h2C, 1'b0, 1'b1);

        exp_w[0] = 32'hB0; exp_w[1] = 32'hB1; exp_w[2] = 32'hB2; exp_w[3] = 32'hB3;
        write_line("wr100", 32'h100, -1, 0, -1);
        bus.req_wvalid = 1'b1;
        bus.req_wdata  = 32'hDEADBEEF;
        read_line("rdwr100", 32'h100, 1'b1, 1'b0);
        bus.req_wvalid = 1'b0;
        read_line("rd100", 32'h100, 1'b0, 1'b0);

        exp_w[0] = 32'hC0; exp_w[1] = 32'hC1; exp_w[2] = 32'hC2; exp_w[3] = 32'hC3;
        write_line("wr40stall", 32'h40, 2, 2, -1);
        read_line("rd40", 32'h40, 1'b0, 1'b0);

        exp_w[0] = 32'hD0; exp_w[1] = 32'hD1; exp_w[2] = 32'hD2; exp_w[3] = 32'hD3;
        write_line("wr40abort", 32'h40, -1, 0, 2);
        exp_w[0] = 32'hD0; exp_w[1] = 32'hD1; exp_w[2] = 32'hC2; exp_w[3] = 32'hC3;
        read_line("rd40abort", 32'h40, 1'b0, 1'b0);

`ifdef RESP_ERR_EN
        bus.req_addr = 32'h400;
        bus.req_read = 1'b1;
        tick();
        chk("err_ack", bus.req_ack, 1'b1);
        bus.req_read = 1'b0;
        repeat (4) begin
            tick();
            chk("err_wait_valid", bus.rsp_valid, 1'b0);
        end
        tick();
        chk("err_valid", bus.rsp_valid, 1'b1);
        chk("err_last", bus.rsp_last, 1'b1);
        chk("err_flag", bus.rsp_err, 1'b1);
        chk("err_state", bus.state, 3'd5);
        chk("err_rdata", bus.rsp_rdata, 32'h0);
        tick();
        chk_idle("err_end");
        chk("err_flag_end", bus.rsp_err, 1'b0);
        $display("error read addr=0x%08h done", 32'h400);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
